// File: rtl/scurve_pkg.sv
// Shared types and default constants for the S-curve single-step injection engine.
package scurve_pkg;

  localparam int CNT_W = 16;

  localparam int DEF_INJECT_NUM   = 1000;
  localparam int DEF_PULSE_PERIOD = 200;
  localparam int DEF_PULSE_WIDTH  = 4;
  localparam int DEF_TRIG_WINDOW  = 100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PULSE  = 3'd1,
    ST_WINDOW = 3'd2,
    ST_GAP    = 3'd3,
    ST_WRITE0 = 3'd4,
    ST_WRITE1 = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/scurve_single_test_sync.sv
// Two-flop synchronizer for the discriminator OR plus a rising-edge detector.
module trigger_sync_edge (
  input  logic Clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic sync_2_d;

  // Resynchronize the asynchronous trigger and keep one extra stage for edge detection.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
    end else begin
      sync_1   <= async_in;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
    end
  end

  assign rise = sync_2 & ~sync_2_d;

endmodule

// File: rtl/scurve_single_test.sv
// One DAC step of the S-curve scan: fire INJECT_NUM CTest pulses, count at most
// one trigger per injection, write {trigger count, injection count} to the FIFO,
// then pulse done.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start, counters cleared
// PULSE   | Ctest_Pulse high for PULSE_WIDTH cycles, triggers accepted
// WINDOW  | pulse low, triggers accepted until period count TRIG_WINDOW-1
// GAP     | triggers ignored until end of injection period
// WRITE0  | write trigger count (stalls while FIFO full)
// WRITE1  | write injection count (stalls while FIFO full)
// DONE    | one-cycle done pulse
module scurve_single_test
  import scurve_pkg::*;
#(
  parameter int INJECT_NUM   = DEF_INJECT_NUM,
  parameter int PULSE_PERIOD = DEF_PULSE_PERIOD,
  parameter int PULSE_WIDTH  = DEF_PULSE_WIDTH,
  parameter int TRIG_WINDOW  = DEF_TRIG_WINDOW
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             Single_Test_Start,
  output logic             Single_Test_Done,
  input  logic             Trigger_In,
  output logic             Ctest_Pulse,
  output logic [CNT_W-1:0] SCurve_Data_fifo_din,
  output logic             SCurve_Data_fifo_wr_en,
  input  logic             SCurve_Data_fifo_full
);

  localparam logic [CNT_W-1:0] INJ_TARGET  = CNT_W'(INJECT_NUM);
  localparam logic [CNT_W-1:0] WIDTH_LAST  = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(TRIG_WINDOW - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PULSE_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] inject_cnt;
  logic [CNT_W-1:0] trigger_cnt;
  logic [CNT_W-1:0] inject_next;
  logic             trig_seen;
  logic             trig_rise;
  logic             trig_accept;
  logic             period_end;
  logic             ctest_q;

  trigger_sync_edge u_trig_sync (
    .Clk      (Clk),
    .reset    (reset),
    .async_in (Trigger_In),
    .rise     (trig_rise)
  );

  assign period_end  = (period_cnt == PERIOD_LAST);
  assign inject_next = inject_cnt + CNT_ONE;
  assign trig_accept = trig_rise && !trig_seen &&
                       ((state == ST_PULSE) || (state == ST_WINDOW));

  // State register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and FIFO/done strobes.
  always_comb begin
    state_nxt              = state;
    Single_Test_Done       = 1'b0;
    SCurve_Data_fifo_wr_en = 1'b0;
    SCurve_Data_fifo_din   = '0;
    case (state)
      ST_IDLE: begin
        if (Single_Test_Start) state_nxt = ST_PULSE;
      end
      ST_PULSE: begin
        if (period_cnt == WIDTH_LAST) state_nxt = ST_WINDOW;
      end
      ST_WINDOW: begin
        // >= so a window shorter than the pulse still closes instead of waiting for a wrap.
        if (period_cnt >= WINDOW_LAST) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (period_end) begin
          if (inject_next == INJ_TARGET) state_nxt = ST_WRITE0;
          else                           state_nxt = ST_PULSE;
        end
      end
      ST_WRITE0: begin
        if (!SCurve_Data_fifo_full) begin
          SCurve_Data_fifo_wr_en = 1'b1;
          SCurve_Data_fifo_din   = trigger_cnt;
          state_nxt              = ST_WRITE1;
        end
      end
      ST_WRITE1: begin
        if (!SCurve_Data_fifo_full) begin
          SCurve_Data_fifo_wr_en = 1'b1;
          SCurve_Data_fifo_din   = INJ_TARGET;
          state_nxt              = ST_DONE;
        end
      end
      ST_DONE: begin
        Single_Test_Done = 1'b1;
        state_nxt        = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Injection strobe registered from the next state so the pulser sees a clean edge.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) ctest_q <= 1'b0;
    else       ctest_q <= (state_nxt == ST_PULSE);
  end

  assign Ctest_Pulse = ctest_q;

  // Period counter: runs through PULSE/WINDOW/GAP and restarts at each injection.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else begin
      case (state)
        ST_PULSE, ST_WINDOW: period_cnt <= period_cnt + CNT_ONE;
        ST_GAP:              period_cnt <= period_end ? '0 : period_cnt + CNT_ONE;
        default:             period_cnt <= '0;
      endcase
    end
  end

  // Injection and trigger bookkeeping; trig_seen limits each injection to one count.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      inject_cnt  <= '0;
      trigger_cnt <= '0;
      trig_seen   <= 1'b0;
    end else if (state == ST_IDLE) begin
      inject_cnt  <= '0;
      trigger_cnt <= '0;
      trig_seen   <= 1'b0;
    end else if (trig_accept) begin
      trigger_cnt <= trigger_cnt + CNT_ONE;
      trig_seen   <= 1'b1;
    end else if ((state == ST_GAP) && period_end) begin
      inject_cnt <= inject_next;
      trig_seen  <= 1'b0;
    end
  end

endmodule
